viterbi_frame_sequencer: RTL
============================

Name: viterbi_frame_sequencer

Overview:
- Frame-level controller for the convolutional-encoder / channel / Viterbi-decoder loop.
- On a start command it generates a pseudo-random payload frame and drives it into the encoder.
- It then appends zero tail bits to flush the encoder trellis, and waits out the decoder latency.
- It compares the decoder output against a delayed copy of the payload, and reports the error count and pass/fail per frame.

Parameters:
- FRAME_LEN, 256, payload bits per frame (>=1).
- TAIL_LEN, 2, zero flush bits after the payload (K-1 for K=3 code; >=0).
- DEC_LATENCY, 20, cycles from enc_bit_o to the matching dec_bit_i, covering channel register plus decoder traceback (>=1).
- CNT_W, 16, width of the error and bit counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start_i  in  1  frame start request; sampled only in IDLE.
- seed_i  in  16  LFSR seed, loaded on an accepted start.
- enc_bit_o  out  1  bit to encoder d_in.
- enc_en_o  out  1  encoder enable.
- dec_bit_i  in  1  decoder d_out.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at frame end.
- err_cnt_o  out  CNT_W  payload bit errors of the last/current frame.
- bit_cnt_o  out  CNT_W  payload bits compared so far.
- frame_pass_o  out  1  err_cnt_o==0, valid from done_o until next start.

Behaviour:
- Reset: enc_bit_o=0, enc_en_o=0, busy_o=0, done_o=0, err_cnt_o=0, bit_cnt_o=0, frame_pass_o=0, state=IDLE. The delay line and LFSR are cleared to 0. Reset mid-frame aborts immediately; no done_o is produced.
- States: IDLE, PAYLOAD, TAIL, DRAIN, DONE. All outputs are registered.
- IDLE:
  - start_i=1 at edge t: load LFSR with seed_i; if seed_i==0, load 16'hACE1.
  - Clear err/bit counters and frame_pass_o.
  - Go to PAYLOAD; the first payload bit is visible at cycle t+1.
- PAYLOAD, FRAME_LEN cycles:
  - enc_en_o=1, enc_bit_o=lfsr[0].
  - LFSR is Fibonacci, taps x^16+x^14+x^13+x^11+1, shifting right each cycle with the feedback bit into [15].
  - Then go to TAIL, or to DRAIN if TAIL_LEN==0.
- TAIL, TAIL_LEN cycles: enc_en_o=1, enc_bit_o=0. Then go to DRAIN.
- DRAIN, DEC_LATENCY cycles: enc_en_o=0, enc_bit_o=0. Then go to DONE.
- DONE, 1 cycle: done_o=1, frame_pass_o=(err_cnt_o==0). Then go to IDLE.
- Frame timing: done_o is asserted at cycle t+FRAME_LEN+TAIL_LEN+DEC_LATENCY+1.
- Reference delay line:
  - DEC_LATENCY deep, shifts every cycle in every state.
  - Input entry is {is_payload = (state==PAYLOAD), enc_bit_o}.
- Compare:
  - When the delay-line output has is_payload=1: bit_cnt_o+=1, and err_cnt_o+=(dec_bit_i ^ ref_bit).
  - Tail and idle positions are never compared.
  - The last compare occurs no later than the final DRAIN cycle, so err_cnt_o is final when done_o=1.
- Counters saturate at all-ones and do not wrap.
- Phase counter: a single phase counter, width clog2(max(FRAME_LEN, TAIL_LEN, DEC_LATENCY)+1), is reloaded on every state entry.
- start_i while busy_o=1: ignored, including in DONE. No queuing.
- dec_bit_i is sampled every cycle regardless of any decoder valid signal; alignment is purely by DEC_LATENCY.

Decomposition:
- Package viterbi_seq_pkg:
  - state enum seq_state_t {IDLE, PAYLOAD, TAIL, DRAIN, DONE}.
  - LFSR tap mask 16'hB400.
  - Default seed 16'hACE1.
- Sub-module seq_delay_line (parameter DEPTH, 2-bit wide shift register with sync reset) holds the {is_payload, bit} reference pipe.
- The LFSR stays inline.

Test Plan:
- Loopback: bench returns enc_bit_o delayed 20 cycles as dec_bit_i, seed 16'h0001, start at t=10 -> done_o at t=10+256+2+20+1=289, err_cnt_o=0, bit_cnt_o=256, frame_pass_o=1.
- Seed zero: seed_i=0 -> first 8 enc_bit_o in PAYLOAD = 1,0,0,0,0,1,1,1 (0xACE1 LSB-first); then 2 tail zeros with enc_en_o=1.
- Single error: loopback with payload bit 100 inverted -> err_cnt_o=1, frame_pass_o=0. Inverting a tail-position bit instead -> err_cnt_o=0.
- All inverted: dec_bit_i = ~delayed enc_bit_o -> err_cnt_o=256, bit_cnt_o=256.
- Start while busy: pulse start_i at PAYLOAD cycle 50 and in the DONE cycle -> no restart; frame completes on original timing; IDLE is reached after DONE.
- Reset mid-frame: rst=1 at PAYLOAD cycle 100 for 1 cycle -> next cycle enc_en_o=0, busy_o=0, counters 0, no done_o. A new start then yields a clean 289-cycle frame with err_cnt_o=0 in loopback.

Source files
------------

// File: rtl/viterbi_seq_pkg.sv
// Shared types and constants for the Viterbi frame sequencer.
// LFSR step helper lives here so the bench-free RTL files stay small.
package viterbi_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    TAIL,
    DRAIN,
    DONE
  } seq_state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Mask bit i is x^(i+1); in a right-shifting Fibonacci register
  // that term sits at bit 15-i.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (LFSR_TAPS[i]) fb = fb ^ v[15-i];
    end
    return {fb, v[15:1]};
  endfunction

endpackage

// File: rtl/viterbi_frame_sequencer_delay.sv
// Reference pipe: {is_payload, bit} delayed DEPTH cycles.
// Cleared by synchronous reset, shifts every cycle.
module seq_delay_line #(
  parameter int DEPTH = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] d_i,
  output logic [1:0] q_o
);

  logic [1:0] pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= 2'b00;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/viterbi_frame_sequencer.sv
// Frame controller: LFSR payload + zero tail into the encoder,
// then scores decoder output against a delayed payload copy.
module viterbi_frame_sequencer
  import viterbi_seq_pkg::*;
#(
  parameter int FRAME_LEN   = 256,
  parameter int TAIL_LEN    = 2,
  parameter int DEC_LATENCY = 20,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [15:0]      seed_i,
  output logic             enc_bit_o,
  output logic             enc_en_o,
  input  logic             dec_bit_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] bit_cnt_o,
  output logic             frame_pass_o
);

  localparam int MAX_A = (FRAME_LEN > TAIL_LEN) ? FRAME_LEN : TAIL_LEN;
  localparam int MAX_P = (MAX_A > DEC_LATENCY) ? MAX_A : DEC_LATENCY;
  localparam int PW    = $clog2(MAX_P + 1);

  localparam logic [PW-1:0] PAY_LAST = PW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] TAIL_LAST =
    PW'((TAIL_LEN > 0) ? TAIL_LEN - 1 : 0);
  localparam logic [PW-1:0] DRN_LAST = PW'(DEC_LATENCY - 1);

  seq_state_t       state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             enc_bit_q, enc_bit_d;
  logic             enc_en_q, enc_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [1:0]       ref_in, ref_out;

  assign ref_in = {state_q == PAYLOAD, enc_bit_q};

  seq_delay_line #(
    .DEPTH(DEC_LATENCY)
  ) u_ref (
    .clk(clk),
    .rst(rst),
    .d_i(ref_in),
    .q_o(ref_out)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    lfsr_d  = lfsr_q;
    err_d   = err_q;
    bit_d   = bit_q;
    pass_d  = pass_q;

    if (ref_out[1]) begin
      if (bit_q != '1) bit_d = bit_q + 1'b1;
      if ((dec_bit_i ^ ref_out[0]) && err_q != '1)
        err_d = err_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = PAYLOAD;
          phase_d = PAY_LAST;
          lfsr_d  = (seed_i == 16'h0) ? DEFAULT_SEED : seed_i;
          err_d   = '0;
          bit_d   = '0;
          pass_d  = 1'b0;
        end
      end
      PAYLOAD: begin
        if (phase_q == '0) begin
          state_d = (TAIL_LEN > 0) ? TAIL : DRAIN;
          phase_d = (TAIL_LEN > 0) ? TAIL_LAST : DRN_LAST;
        end else begin
          phase_d = phase_q - 1'b1;
          lfsr_d  = lfsr_step(lfsr_q);
        end
      end
      TAIL: begin
        if (phase_q == '0) begin
          state_d = DRAIN;
          phase_d = DRN_LAST;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      DRAIN: begin
        if (phase_q == '0) begin
          state_d = DONE;
          phase_d = '0;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        phase_d = '0;
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    enc_en_d  = (state_d == PAYLOAD) || (state_d == TAIL);
    enc_bit_d = (state_d == PAYLOAD) && lfsr_d[0];
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    if (state_d == DONE) pass_d = (err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      lfsr_q    <= '0;
      enc_bit_q <= 1'b0;
      enc_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      bit_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      lfsr_q    <= lfsr_d;
      enc_bit_q <= enc_bit_d;
      enc_en_q  <= enc_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      bit_q     <= bit_d;
    end
  end

  assign enc_bit_o    = enc_bit_q;
  assign enc_en_o     = enc_en_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign frame_pass_o = pass_q;
  assign err_cnt_o    = err_q;
  assign bit_cnt_o    = bit_q;

endmodule
